// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL single-beat responder over a DEPTH x 32-bit register array.
// Latency: the response appears one cycle after the A-channel request is accepted.
// Backpressure: a single D slot; a_ready falls only while the slot is full and d_ready is low.
module tl_ul_sram_responder #(
    parameter int DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [2:0]  a_size,
    input  logic [6:0]  a_source,
    input  logic [13:0] a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [2:0]  d_size,
    output logic [6:0]  d_source,
    output logic        d_sink,
    output logic        d_denied,
    output logic        d_corrupt,
    output logic [31:0] d_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [14:0] ADDR_LIMIT = 15'(4 * DEPTH);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            slot_load;
    logic            a_fire;
    logic            d_fire;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   idx;
    logic [3:0]      exp_mask;
    logic            is_get;
    logic            is_put_full;
    logic            is_put_partial;
    logic            size_ok;
    logic            align_ok;
    logic            range_ok;
    logic            mask_ok;
    logic            denied;
    logic            wr_en;

    assign idx = a_address[AW+1:2];

    // Request decode: legal-byte mask for the size/offset and the denial verdict.
    always_comb begin
        exp_mask       = 4'h0;
        align_ok       = 1'b0;
        mask_ok        = 1'b1;
        is_get         = (a_opcode == OP_GET);
        is_put_full    = (a_opcode == OP_PUT_FULL);
        is_put_partial = (a_opcode == OP_PUT_PARTIAL);
        size_ok        = (a_size <= 3'd2);
        range_ok       = ({1'b0, a_address} < ADDR_LIMIT);
        case (a_size)
            3'd0: begin
                exp_mask = 4'b0001 << a_address[1:0];
                align_ok = 1'b1;
            end
            3'd1: begin
                exp_mask = 4'b0011 << {a_address[1], 1'b0};
                align_ok = ~a_address[0];
            end
            3'd2: begin
                exp_mask = 4'hF;
                align_ok = (a_address[1:0] == 2'b00);
            end
            default: begin
                exp_mask = 4'h0;
                align_ok = 1'b0;
            end
        endcase
        if (is_put_full) begin
            mask_ok = (a_mask == exp_mask);
        end else if (is_put_partial) begin
            mask_ok = (a_mask != 4'h0) && ((a_mask & ~exp_mask) == 4'h0);
        end
        denied = ~(is_get | is_put_full | is_put_partial) | ~size_ok | ~align_ok |
                 ~range_ok | (a_param != 3'd0) | ~mask_ok;
    end

    // Reset keeps the A side open so upstream never stalls on a flushed slot.
    assign a_ready = ~reset_n | (state_q == EMPTY) | d_ready;
    assign d_valid = (state_q == FULL);
    assign a_fire  = a_valid & a_ready;
    assign d_fire  = d_valid & d_ready;
    assign wr_en   = a_fire & reset_n & (is_put_full | is_put_partial) & ~denied;

    // Slot FSM: a new request always wins the slot, even while the old one drains.
    always_comb begin
        state_d   = state_q;
        slot_load = 1'b0;
        if (a_fire) begin
            state_d   = FULL;
            slot_load = 1'b1;
        end else if (d_fire) begin
            state_d = EMPTY;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Response slot: everything on the D channel comes from here.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            d_opcode  <= 3'd0;
            d_size    <= 3'd0;
            d_source  <= 7'd0;
            d_denied  <= 1'b0;
            d_corrupt <= 1'b0;
            d_data    <= 32'd0;
        end else if (slot_load) begin
            d_opcode  <= is_get ? 3'd1 : 3'd0;
            d_size    <= a_size;
            d_source  <= a_source;
            d_denied  <= denied;
            d_corrupt <= denied & is_get;
            d_data    <= (is_get && !denied) ? mem[idx] : 32'd0;
        end
    end

    // Byte-enabled array write; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && a_mask[b]) begin
                mem[idx][8*b +: 8] <= a_data[8*b +: 8];
            end
        end
    end

    assign d_param = 2'd0;
    assign d_sink  = 1'b0;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Randomized and directed bench for tl_ul_sram_responder against a behavioural model.
// Latency: cycle-stepped; every step drives inputs at the falling edge and checks before the rising edge.
// Backpressure: d_ready is driven per step (directed stalls and random toggling).
module tb_tl_ul_sram_responder;

    localparam int DEPTH = 16;

    logic        clock;
    logic        reset_n;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [6:0]  a_source;
    logic [13:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [6:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic        d_corrupt;
    logic [31:0] d_data;

    tl_ul_sram_responder #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_denied  (d_denied),
        .d_corrupt (d_corrupt),
        .d_data    (d_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned op;
        int unsigned size;
        int unsigned src;
        bit          den;
        bit          cor;
        logic [31:0] data;
    } resp_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned dfire_cnt = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_valid = 1'b0;
    resp_t       m_slot;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned legal_mask(input int unsigned sz, input int unsigned addr);
        if (sz == 0) return 1 << (addr % 4);
        if (sz == 1) return 3 << (2 * ((addr / 2) % 2));
        if (sz == 2) return 15;
        return 0;
    endfunction

    function automatic bit is_denied(input int unsigned op, input int unsigned prm,
                                     input int unsigned sz, input int unsigned addr,
                                     input int unsigned msk);
        int unsigned em;
        em = legal_mask(sz, addr);
        if (!(op == 0 || op == 1 || op == 4)) return 1'b1;
        if (sz > 2) return 1'b1;
        if ((addr % (1 << sz)) != 0) return 1'b1;
        if (addr >= 4 * DEPTH) return 1'b1;
        if (prm != 0) return 1'b1;
        if (op == 0 && msk != em) return 1'b1;
        if (op == 1 && (msk == 0 || (msk & ~em) != 0)) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: form the response from the current array, then apply any write.
    task automatic model_accept(input int unsigned op, input int unsigned prm, input int unsigned sz,
                                input int unsigned src, input int unsigned addr,
                                input int unsigned msk, input logic [31:0] dat);
        resp_t r;
        r.den  = is_denied(op, prm, sz, addr, msk);
        r.op   = (op == 4) ? 1 : 0;
        r.size = sz;
        r.src  = src;
        r.cor  = r.den && (op == 4);
        r.data = (op == 4 && !r.den) ? m_mem[addr / 4] : 32'd0;
        if (!r.den && (op == 0 || op == 1)) begin
            for (int b = 0; b < 4; b++) begin
                if (msk[b]) m_mem[addr / 4][8*b +: 8] = dat[8*b +: 8];
            end
        end
        m_slot  = r;
        m_valid = 1'b1;
    endtask

    // One clock: drive, compare against the model, advance the model, cross the edge.
    task automatic step(input bit rn, input bit av, input int unsigned op, input int unsigned prm,
                        input int unsigned sz, input int unsigned src, input int unsigned addr,
                        input int unsigned msk, input logic [31:0] dat, input bit dr);
        bit exp_ar;
        bit dfire;
        bit afire;
        reset_n   = rn;
        a_valid   = av;
        a_opcode  = 3'(op);
        a_param   = 3'(prm);
        a_size    = 3'(sz);
        a_source  = 7'(src);
        a_address = 14'(addr);
        a_mask    = 4'(msk);
        a_data    = dat;
        d_ready   = dr;
        #1;
        exp_ar = !rn || !m_valid || dr;
        check("a_ready", {31'd0, a_ready}, {31'd0, exp_ar});
        check("d_valid", {31'd0, d_valid}, {31'd0, m_valid});
        check("d_param", {30'd0, d_param}, 32'd0);
        check("d_sink", {31'd0, d_sink}, 32'd0);
        if (m_valid) begin
            check("d_opcode", {29'd0, d_opcode}, m_slot.op);
            check("d_size", {29'd0, d_size}, m_slot.size);
            check("d_source", {25'd0, d_source}, m_slot.src);
            check("d_denied", {31'd0, d_denied}, {31'd0, m_slot.den});
            check("d_corrupt", {31'd0, d_corrupt}, {31'd0, m_slot.cor});
            check("d_data", d_data, m_slot.data);
        end
        dfire = m_valid && dr;
        afire = av && exp_ar;
        if (!rn) begin
            m_valid = 1'b0;
        end else begin
            if (dfire) dfire_cnt++;
            if (afire) model_accept(op, prm, sz, src, addr, msk, dat);
            else if (dfire) m_valid = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input bit dr);
        step(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 32'd0, dr);
    endtask

    logic [31:0] hold_data;
    logic [6:0]  hold_src;
    logic [31:0] keep_word;

    initial begin
        int unsigned op, sz, addr, msk, prm, off, r;
        reset_n = 1'b0; a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd0;
        a_source = 7'd0; a_address = 14'd0; a_mask = 4'd0; a_data = 32'd0; d_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst d_valid", {31'd0, d_valid}, 32'd0);
        check("rst d_data", d_data, 32'd0);
        check("rst d_opcode", {29'd0, d_opcode}, 32'd0);
        check("rst d_source", {25'd0, d_source}, 32'd0);
        check("rst d_size", {29'd0, d_size}, 32'd0);
        check("rst d_denied", {31'd0, d_denied}, 32'd0);
        check("rst d_corrupt", {31'd0, d_corrupt}, 32'd0);
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b0);

        // Fill the whole array so every later read has a known value.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 0, 0, 2, i, 4 * i, 15, $urandom, 1'b1);
        idle(1'b1);

        // PutFull then Get of the same word.
        step(1'b1, 1'b1, 0, 0, 2, 5, 'h008, 'hF, 32'hDEADBEEF, 1'b1);
        check("putfull d_valid", {31'd0, d_valid}, 32'd1);
        check("putfull d_opcode", {29'd0, d_opcode}, 32'd0);
        check("putfull d_source", {25'd0, d_source}, 32'd5);
        check("putfull d_denied", {31'd0, d_denied}, 32'd0);
        step(1'b1, 1'b1, 4, 0, 2, 1, 'h008, 'hF, 32'd0, 1'b1);
        check("get d_data", d_data, 32'hDEADBEEF);
        check("get d_opcode", {29'd0, d_opcode}, 32'd1);

        // PutPartial into byte 1.
        step(1'b1, 1'b1, 1, 0, 2, 2, 'h008, 'b0010, 32'h0000AA00, 1'b1);
        step(1'b1, 1'b1, 4, 0, 2, 3, 'h008, 'hF, 32'd0, 1'b1);
        check("partial get", d_data, 32'hDEADAAEF);

        // Misaligned Get and unsupported opcode.
        step(1'b1, 1'b1, 4, 0, 2, 4, 'h006, 'hF, 32'd0, 1'b1);
        check("misalign denied", {31'd0, d_denied}, 32'd1);
        check("misalign corrupt", {31'd0, d_corrupt}, 32'd1);
        check("misalign data", d_data, 32'd0);
        step(1'b1, 1'b1, 2, 0, 2, 6, 'h008, 'hF, 32'h12345678, 1'b1);
        check("op2 denied", {31'd0, d_denied}, 32'd1);
        check("op2 opcode", {29'd0, d_opcode}, 32'd0);
        check("op2 corrupt", {31'd0, d_corrupt}, 32'd0);
        step(1'b1, 1'b1, 4, 0, 2, 7, 'h008, 'hF, 32'd0, 1'b1);
        check("after deny data", d_data, 32'hDEADAAEF);

        // Stall the D channel for 5 cycles with a request waiting on A.
        step(1'b1, 1'b1, 4, 0, 2, 9, 'h00C, 'hF, 32'd0, 1'b1);
        hold_data = d_data;
        hold_src  = d_source;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 0, 0, 2, 10, 'h000, 'hF, 32'hCAFEF00D, 1'b0);
            check("stall a_ready", {31'd0, a_ready}, 32'd0);
            check("stall data", d_data, hold_data);
            check("stall source", {25'd0, d_source}, {25'd0, hold_src});
        end
        idle(1'b1);

        // Ten back-to-back requests drain in ten consecutive D-fires.
        dfire_cnt = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 4, 0, 2, 20 + i, 4 * (i % DEPTH), 'hF, 32'd0, 1'b1);
        idle(1'b1);
        check("stream dfires", dfire_cnt, 32'd10);

        // Out-of-range Get.
        step(1'b1, 1'b1, 4, 0, 2, 11, 'h040, 'hF, 32'd0, 1'b1);
        check("oob denied", {31'd0, d_denied}, 32'd1);
        check("oob data", d_data, 32'd0);
        idle(1'b1);

        // Reset while a response is pending: it is dropped, the array is kept.
        keep_word = 32'h5A5AC3C3;
        step(1'b1, 1'b1, 0, 0, 2, 12, 'h00C, 'hF, keep_word, 1'b0);
        check("pre-reset d_valid", {31'd0, d_valid}, 32'd1);
        step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 32'd0, 1'b0);
        check("post-reset d_valid", {31'd0, d_valid}, 32'd0);
        idle(1'b1);
        check("no late delivery", {31'd0, d_valid}, 32'd0);
        step(1'b1, 1'b1, 4, 0, 2, 13, 'h00C, 'hF, 32'd0, 1'b1);
        check("retained data", d_data, keep_word);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 9);
            op = (r < 4) ? 4 : (r < 6) ? 0 : (r < 8) ? 1 : $urandom_range(0, 7);
            sz = ($urandom_range(0, 9) < 7) ? 2 : $urandom_range(0, 3);
            off = (sz == 0) ? $urandom_range(0, 3) : (sz == 1) ? 2 * $urandom_range(0, 1) : 0;
            addr = 4 * $urandom_range(0, DEPTH - 1) + off;
            if ($urandom_range(0, 15) == 0) addr = $urandom_range(0, 16383);
            msk = legal_mask(sz, addr);
            if (op == 1) msk = msk & $urandom_range(1, 15);
            if ($urandom_range(0, 15) == 0) msk = $urandom_range(0, 15);
            prm = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 7) : 0;
            step(1'b1, $urandom_range(0, 3) != 0, op, prm, sz, $urandom_range(0, 127), addr, msk,
                 $urandom, $urandom_range(0, 3) != 0);
        end
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
